// File: rtl/fifo_axis_reader.sv
// Read-side drain engine: pops a FIFO with one-cycle read latency into a 2-entry
// skid buffer and streams it out as valid/ready beats framed into PKT_LEN-beat packets.
module fifo_axis_reader #(
    parameter int DATA_SIZE = 8,
    parameter int PKT_LEN   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_last,
    output logic [CNT_W-1:0]     pkt_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

    logic [1:0]           occ_q, occ_d;
    logic                 inf_q;
    logic [DATA_SIZE-1:0] head_q, head_d;
    logic [DATA_SIZE-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]     bidx_q, bidx_d;
    logic [CNT_W-1:0]     pkt_q, pkt_d;
    logic                 pop;
    logic [1:0]           occ_kept;
    logic [2:0]           committed;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = head_q;
    assign m_last  = m_valid & (bidx_q == LAST_IDX);
    assign pkt_cnt = pkt_q;
    assign pop     = m_valid & m_ready;

    always_comb begin
        committed  = {1'b0, occ_q} + {2'b00, inf_q} - {2'b00, pop};
        // Issue a pop only if the word it returns is guaranteed a buffer slot.
        fifo_rd_en = rst & ~fifo_empty & (committed < 3'd2);
        occ_kept   = occ_q - {1'b0, pop};
        occ_d      = committed[1:0];
        head_d     = head_q;
        skid_d     = skid_q;
        bidx_d     = bidx_q;
        pkt_d      = pkt_q;
        if (pop && occ_q == 2'd2) begin
            head_d = skid_q;
        end
        // The returning word lands behind whatever survives this cycle's pop.
        if (inf_q) begin
            if (occ_kept == 2'd0) begin
                head_d = fifo_data;
            end else begin
                skid_d = fifo_data;
            end
        end
        if (pop) begin
            if (bidx_q == LAST_IDX) begin
                bidx_d = '0;
                pkt_d  = pkt_q + 1'b1;
            end else begin
                bidx_d = bidx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= 2'd0;
            inf_q  <= 1'b0;
            head_q <= '0;
            skid_q <= '0;
            bidx_q <= '0;
            pkt_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            inf_q  <= fifo_rd_en;
            head_q <= head_d;
            skid_q <= skid_d;
            bidx_q <= bidx_d;
            pkt_q  <= pkt_d;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge rd_clk) disable iff (!rst)
        !(inf_q && occ_q == 2'd2 && !pop))
        else $error("fifo_axis_reader: push into full skid buffer without pop");

    a_stall_stable : assert property (@(posedge rd_clk) disable iff (!rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)))
        else $error("fifo_axis_reader: m_data changed or m_valid dropped while stalled");
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader: a queue-based FIFO model feeds two DUT
// instances (PKT_LEN=4/CNT_W=16 and PKT_LEN=2/CNT_W=2) and a monitor checks beats.
module tb_fifo_axis_reader;

    localparam int DW  = 8;
    localparam int PL  = 4;
    localparam int CW  = 16;
    localparam int PL2 = 2;
    localparam int CW2 = 2;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          m_ready = 1'b0;
    logic [DW-1:0] fifo_data = '0;

    logic          rd_en_a, valid_a, last_a;
    logic [DW-1:0] data_a;
    logic [CW-1:0] pkt_a;
    logic          rd_en_b, valid_b, last_b;
    logic [DW-1:0] data_b;
    logic [CW2-1:0] pkt_b;

    fifo_axis_reader #(.DATA_SIZE(DW), .PKT_LEN(PL), .CNT_W(CW)) dut_a (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_a),
        .fifo_data(fifo_data), .m_valid(valid_a), .m_ready(m_ready), .m_data(data_a),
        .m_last(last_a), .pkt_cnt(pkt_a));

    fifo_axis_reader #(.DATA_SIZE(DW), .PKT_LEN(PL2), .CNT_W(CW2)) dut_b (
        .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_b),
        .fifo_data(fifo_data), .m_valid(valid_b), .m_ready(m_ready), .m_data(data_b),
        .m_last(last_b), .pkt_cnt(pkt_b));

    always #5 rd_clk = ~rd_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int beats = 0;
    int rden_cnt, first_rden, last_rden;
    int hs_cnt, first_hs, last_hs, first_valid;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fifo_w, mon_e, prev_data;
    logic          popnow, prev_stall, prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #2;
    endtask

    task automatic clr_stats();
        rden_cnt = 0; first_rden = -1; last_rden = -1;
        hs_cnt = 0; first_hs = -1; last_hs = -1; first_valid = -1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || valid_a) && n < budget) begin
            tick(1);
            n++;
        end
        check("drain_complete", 32'(exp_q.size() == 0 && fifo_q.size() == 0 && !valid_a), 32'd1);
    endtask

    always @(posedge rd_clk) cyc <= cyc + 1;

    // FIFO model: a pop seen at the negedge returns its word on the following cycle.
    initial begin
        popnow = 1'b0;
        fifo_w = '0;
        forever begin
            @(negedge rd_clk);
            popnow = 1'b0;
            if (rst && rd_en_a) begin
                check("rd_en_while_empty", 32'(fifo_empty), 32'd0);
                if (fifo_q.size() == 0) begin
                    check("fifo_underflow", 32'd1, 32'd0);
                end else begin
                    fifo_w = fifo_q.pop_front();
                    exp_q.push_back(fifo_w);
                    popnow = 1'b1;
                    rden_cnt++;
                    if (first_rden < 0) first_rden = cyc;
                    last_rden = cyc;
                end
            end
            @(posedge rd_clk);
            #1;
            fifo_data  = popnow ? fifo_w : DW'($urandom);
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: stream protocol, ordering, framing and packet count.
    initial begin
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge rd_clk);
            if (!rst) begin
                check("rst_rd_en", 32'(rd_en_a | rd_en_b), 32'd0);
                check("rst_valid", 32'(valid_a | valid_b), 32'd0);
                check("rst_data", 32'({data_a, data_b}), 32'd0);
                check("rst_last", 32'(last_a | last_b), 32'd0);
                check("rst_pkt", 32'({pkt_a, pkt_b}), 32'd0);
                prev_stall = 1'b0;
            end else begin
                check("pkt_cnt_a", 32'(pkt_a), 32'((beats / PL) % (1 << CW)));
                check("pkt_cnt_b", 32'(pkt_b), 32'((beats / PL2) % (1 << CW2)));
                if (prev_stall) begin
                    check("stall_valid", 32'(valid_a), 32'd1);
                    check("stall_data", 32'(data_a), 32'(prev_data));
                    check("stall_last", 32'(last_a), 32'(prev_last));
                end
                if (valid_a && first_valid < 0) first_valid = cyc;
                if (valid_a && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("data_a", 32'(data_a), 32'(mon_e));
                        check("data_b", 32'(data_b), 32'(mon_e));
                    end
                    check("last_a", 32'(last_a), 32'((beats % PL) == PL - 1));
                    check("last_b", 32'(last_b), 32'((beats % PL2) == PL2 - 1));
                    beats++;
                    hs_cnt++;
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end else if (!valid_a) begin
                    check("idle_last", 32'(last_a | last_b), 32'd0);
                end
                prev_stall = valid_a && !m_ready;
                prev_data  = data_a;
                prev_last  = last_a;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int thr;
        clr_stats();
        // Reset with words already waiting in the FIFO.
        rst = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 3; i++) fifo_q.push_back(DW'(8'hA0 + i));
        tick(4);
        fifo_q.delete();
        exp_q.delete();
        beats = 0;
        tick(2);
        rst = 1'b1;
        tick(2);

        // Full-rate burst of 8 words.
        clr_stats();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        tick(14);
        check("burst_rden_cnt", 32'(rden_cnt), 32'd8);
        check("burst_rden_span", 32'(last_rden - first_rden), 32'd7);
        check("burst_latency", 32'(first_valid - first_rden), 32'd2);
        check("burst_hs_cnt", 32'(hs_cnt), 32'd8);
        check("burst_hs_span", 32'(last_hs - first_hs), 32'd7);
        check("burst_pkt_cnt", 32'(pkt_a), 32'd2);

        // Stall for 10 cycles, then release.
        clr_stats();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i));
        tick(10);
        check("stall_rden_cnt", 32'(rden_cnt), 32'd2);
        check("stall_head_valid", 32'(valid_a), 32'd1);
        check("stall_head_data", 32'(data_a), 32'h01);
        m_ready = 1'b1;
        tick(12);
        check("release_hs_cnt", 32'(hs_cnt), 32'd8);
        check("release_hs_span", 32'(last_hs - first_hs), 32'd7);
        check("release_rden_cnt", 32'(rden_cnt), 32'd8);
        check("release_pkt_cnt", 32'(pkt_a), 32'd4);

        // Toggling ready while the FIFO runs dry after 3 words.
        clr_stats();
        for (int i = 1; i <= 3; i++) fifo_q.push_back(DW'(i));
        for (int i = 0; i < 20; i++) begin
            m_ready = (i % 2 == 0);
            tick(1);
        end
        check("toggle_hs_cnt", 32'(hs_cnt), 32'd3);
        check("toggle_rden_cnt", 32'(rden_cnt), 32'd3);
        check("toggle_valid_low", 32'(valid_a), 32'd0);
        check("toggle_exp_empty", 32'(exp_q.size()), 32'd0);
        check("toggle_pkt_b", 32'(pkt_b), 32'd1);

        // Asynchronous reset with one word buffered and one in flight.
        clr_stats();
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(8'h10 + i));
        tick(3);
        check("prereset_valid", 32'(valid_a), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        beats = 0;
        #1;
        check("async_valid", 32'(valid_a), 32'd0);
        check("async_data", 32'(data_a), 32'd0);
        check("async_pkt", 32'(pkt_a), 32'd0);
        tick(2);
        rst = 1'b1;
        clr_stats();
        m_ready = 1'b1;
        tick(10);
        check("postreset_hs_cnt", 32'(hs_cnt), 32'd2);
        check("postreset_pkt", 32'(pkt_a), 32'd0);

        // Randomized traffic with varying backpressure.
        clr_stats();
        thr = 90;
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) thr = (i % 300 == 0) ? 90 : ((i % 300 == 100) ? 50 : 20);
            if ($urandom_range(2, 0) == 0 && fifo_q.size() < 12) fifo_q.push_back(DW'($urandom));
            m_ready = ($urandom_range(99, 0) < thr);
            tick(1);
        end
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_axis_reader.md
Name: fifo_axis_reader

Overview:
Read-side drain engine for the dual-clock FIFO, living entirely in the read clock domain. It pops words from the FIFO read port (one-cycle read latency after rd_en), buffers them in a 2-entry skid buffer, and presents them as a valid/ready stream master to the downstream consumer. It also frames the stream into fixed-length packets with a last-beat flag and counts completed packets.

Parameters:
DATA_SIZE, 8, width of FIFO word and stream data
PKT_LEN, 4, beats per packet; legal range 2..65535
CNT_W, 16, width of beat counter and packet counter

Ports:
rd_clk  input  1  read-domain clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
fifo_empty  input  1  FIFO empty flag, read domain
fifo_rd_en  output  1  FIFO pop request; one word per cycle asserted
fifo_data  input  DATA_SIZE  FIFO read data, valid the cycle after fifo_rd_en
m_valid  output  1  stream data valid
m_ready  input  1  downstream ready
m_data  output  DATA_SIZE  stream data
m_last  output  1  final beat of current packet
pkt_cnt  output  CNT_W  completed packets, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst low, asynchronous): occupancy=0, inflight=0, beat index=0, pkt_cnt=0, m_valid=0, m_data=0, m_last=0. fifo_rd_en forced 0 while rst is low.
- State: occupancy occ in 0..2 (head/skid entries), inflight flag inf (pop issued last cycle), beat index bidx in 0..PKT_LEN-1.
- pop = m_valid & m_ready. fifo_rd_en = !fifo_empty & ((occ + inf - pop) < 2). This is combinational from m_ready by design so throughput is 1 beat/cycle.
- inf <= fifo_rd_en each cycle. When inf=1, fifo_data is written into the buffer that cycle, behind any existing entry.
- Next occ = occ + inf - pop. Never exceeds 2. A push into an empty buffer with simultaneous pop is illegal because m_valid=0.
- m_valid = (occ != 0). m_data is the head entry. On pop with occ=2, the skid entry moves to the head the same edge.
- Stream rule: while m_valid=1 and m_ready=0, m_data and m_last hold stable and m_valid does not drop.
- Order: words leave in exactly FIFO pop order. There is no loss and no duplication.
- Latency: a word in a non-empty FIFO with idle buffer appears on m_valid 2 cycles after fifo_rd_en is sampled high. That is 1 cycle of FIFO latency plus 1 buffer register.
- m_last = m_valid & (bidx == PKT_LEN-1).
- On pop: if bidx == PKT_LEN-1, then bidx <= 0 and pkt_cnt <= pkt_cnt+1 (wraps). Otherwise bidx <= bidx+1.
- fifo_empty high with inf=1: the in-flight word is still captured. No new pop is issued.
- Backpressure: with m_ready low, at most 2 words are outstanding (occ+inf ≤ 2). fifo_rd_en stays 0 once the buffer is committed full.
- Reset mid-operation: in-flight and buffered words are discarded. After rst deasserts, the first delivered beat has bidx=0.
- Simulation-only check: error message if a push occurs with occ=2 and no pop, or if m_data changes while stalled.

Test Plan:
- Reset with FIFO holding 3 words → during rst low, fifo_rd_en=0, m_valid=0, m_data=0, m_last=0, pkt_cnt=0.
- FIFO preloaded with 0x01..0x08, m_ready=1 → fifo_rd_en high for 8 consecutive cycles. m_data=0x01..0x08 on 8 consecutive cycles with first valid 2 cycles after the first fifo_rd_en. m_last high on 0x04 and 0x08. pkt_cnt=2.
- Same preload, m_ready=0 for 10 cycles, then 1 → exactly 2 pops issued. m_data=0x01 held stable throughout the stall. After release, 0x01..0x08 delivered in order with no gap.
- m_ready toggling 1,0,1,0 with FIFO emptying mid-burst (3 words) → 0x01,0x02,0x03 delivered once each. m_valid drops only after 0x03 is popped. No fifo_rd_en while fifo_empty=1.
- PKT_LEN=2, CNT_W=2, stream 10 beats → m_last on every second beat. pkt_cnt sequence 1,2,3,0,1.
- Assert rst low while occ=2 and inf=1 → m_valid=0 immediately (asynchronous). After release, the next delivered word has m_last=0 and bidx restarts at 0.
